// File: rtl/seq_shift_add_mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
//   state_e : controller states (IDLE, RUN, DONE)
//   steps() : number of RUN edges per operation (WIDTH / DIGIT_BITS)
//   cnt_w() : width of the step and cycle counters
package seq_shift_add_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int steps(input int width, input int digit_bits);
    return width / digit_bits;
  endfunction

  function automatic int cnt_w(input int width, input int digit_bits);
    return $clog2(steps(width, digit_bits)) + 1;
  endfunction

endpackage

// File: rtl/seq_shift_add_mul_if.sv
// Handshake and data bundle of the multiplier.
//   master : operand source / result sink (drives in_valid, a, b, stall, out_ready)
//   slave  : the multiplier (drives in_ready, out_valid, o, busy, cycles)
interface seq_shift_add_mul_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               stall;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] o;
  logic               busy;
  logic [CNT_W-1:0]   cycles;

  modport master (
    output in_valid, a, b, stall, out_ready,
    input  in_ready, out_valid, o, busy, cycles
  );

  modport slave (
    input  in_valid, a, b, stall, out_ready,
    output in_ready, out_valid, o, busy, cycles
  );
endinterface

// File: rtl/seq_shift_add_mul_digit_step.sv
// One accumulation step: acc_next_o = acc_i + (a_i * digit_i) << shamt_i.
//   acc_i      : running 2*WIDTH accumulator
//   a_i        : multiplicand magnitude
//   digit_i    : low DIGIT_BITS of the remaining multiplier
//   shamt_i    : bit position of this digit
//   acc_next_o : updated accumulator (wraps mod 2^(2*WIDTH))
module seq_shift_add_mul_digit_step #(
  parameter int WIDTH      = 16,
  parameter int DIGIT_BITS = 1,
  parameter int SH_W       = 5
) (
  input  logic [2*WIDTH-1:0]    acc_i,
  input  logic [WIDTH-1:0]      a_i,
  input  logic [DIGIT_BITS-1:0] digit_i,
  input  logic [SH_W-1:0]       shamt_i,
  output logic [2*WIDTH-1:0]    acc_next_o
);
  localparam int PP_W = WIDTH + DIGIT_BITS;

  logic [PP_W-1:0]    pp;
  logic [2*WIDTH-1:0] pp_ext;

  assign pp         = PP_W'(a_i) * PP_W'(digit_i);
  // Zero-extend before shifting so the top digit never loses carry bits.
  assign pp_ext     = (2*WIDTH)'(pp);
  assign acc_next_o = acc_i + (pp_ext << shamt_i);
endmodule

// File: rtl/seq_shift_add_mul.sv
// Sequential shift-and-add multiplier, DIGIT_BITS multiplier bits per RUN edge.
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : seq_shift_add_mul_if.slave (operand/result handshakes, stall, busy, cycles)
// Optional feature: EARLY_TERM_EN -- leave RUN as soon as the multiplicand or the
// remaining multiplier is zero. Without it every op takes exactly STEPS RUN edges.
//
// state | meaning
// IDLE  | waiting for an operand transfer (in_ready=1)
// RUN   | accumulating one digit per non-stalled edge
// DONE  | product held in o, waiting for the result transfer
module seq_shift_add_mul
  import seq_shift_add_mul_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIGIT_BITS = 1,
  parameter bit SIGNED     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  seq_shift_add_mul_if.slave bus
);
  localparam int STEPS = steps(WIDTH, DIGIT_BITS);
  localparam int CNT_W = cnt_w(WIDTH, DIGIT_BITS);
  localparam int SH_W  = $clog2(WIDTH) + 1;
  localparam int PW    = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    o_q, o_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    acc_next;
  logic [SH_W-1:0]  shamt;
  logic             in_xfer;
  logic             out_xfer;

  // -2^(W-1) negates to itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return (SIGNED && v[WIDTH-1]) ? -v : v;
  endfunction

  assign shamt = SH_W'(cnt_q) * SH_W'(DIGIT_BITS);

  seq_shift_add_mul_digit_step #(
    .WIDTH      (WIDTH),
    .DIGIT_BITS (DIGIT_BITS),
    .SH_W       (SH_W)
  ) u_step (
    .acc_i      (acc_q),
    .a_i        (a_q),
    .digit_i    (b_q[DIGIT_BITS-1:0]),
    .shamt_i    (shamt),
    .acc_next_o (acc_next)
  );

  assign bus.in_ready  = (state_q == IDLE) && !bus.stall;
  assign bus.out_valid = (state_q == DONE) && !bus.stall;
  assign bus.busy      = (state_q != IDLE);
  assign bus.o         = o_q;
  assign bus.cycles    = cyc_q;

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    o_d     = o_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    neg_d   = neg_q;
    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          a_d     = mag(bus.a);
          b_d     = mag(bus.b);
          neg_d   = SIGNED && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          cyc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cyc_d = cyc_q + CNT_W'(1);
`ifdef EARLY_TERM_EN
        if (a_q == '0 || b_q == '0) begin
          state_d = DONE;
          o_d     = neg_q ? -acc_q : acc_q;
        end else
`endif
        begin
          acc_d = acc_next;
          b_d   = b_q >> DIGIT_BITS;
          cnt_d = cnt_q + CNT_W'(1);
          // The last digit lands in o on the same edge it is accumulated.
          if (cnt_q == CNT_W'(STEPS - 1)) begin
            state_d = DONE;
            o_d     = neg_q ? -acc_next : acc_next;
          end
        end
      end
      DONE: begin
        if (out_xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // stall freezes every register, including the FSM and cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      o_q     <= '0;
      cnt_q   <= '0;
      cyc_q   <= '0;
      neg_q   <= 1'b0;
    end else if (!bus.stall) begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      neg_q   <= neg_d;
    end
  end
endmodule
